// File: rtl/clk_pkg.sv
// Shared definitions for the clock-enable sequencer.
// Holds the sequencer FSM state type, the system clock rate and the
// NUM/DEN ratio of every enable channel (enable rate = SYS_HZ*NUM/DEN).
package clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } clk_state_e;

  localparam int SYS_HZ  = 72_000_000;

  localparam int CPU_NUM = 1;   // 12 MHz
  localparam int CPU_DEN = 6;
  localparam int SND_NUM = 7;   // 7 MHz
  localparam int SND_DEN = 72;
  localparam int YM_NUM  = 7;   // 3.5 MHz
  localparam int YM_DEN  = 144;
  localparam int OKI_NUM = 1;   // 4 MHz
  localparam int OKI_DEN = 18;
  localparam int PIX_NUM = 1;   // 6 MHz
  localparam int PIX_DEN = 12;

endpackage

// File: rtl/frac_ce.sv
// Fractional clock-enable generator.
// Adds NUM to an ACC_W-bit accumulator every active cycle; whenever the sum
// reaches DEN a single-cycle registered enable is produced and DEN is
// subtracted, giving an average rate of NUM/DEN of clk_sys.
// Ports:
//   clk_sys - system clock
//   reset_n - asynchronous active-low reset
//   run     - channel may advance on this edge; when low the accumulator is
//             cleared so the first pulse after release has a fixed phase
//   hold    - freeze the accumulator (phase preserved) and suppress ce
//   ce      - registered enable pulse, one clk_sys cycle wide
module frac_ce #(
  parameter int NUM   = 1,
  parameter int DEN   = 6,
  parameter int ACC_W = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic run,
  input  logic hold,
  output logic ce
);

  localparam logic [ACC_W:0] NUM_V = (ACC_W + 1)'(NUM);
  localparam logic [ACC_W:0] DEN_V = (ACC_W + 1)'(DEN);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_wrap;

  // One extra bit on the sum so acc + NUM can never wrap before compare.
  assign sum = {1'b0, acc} + NUM_V;
  // Only used when sum >= DEN, so the remainder is below NUM and fits ACC_W.
  assign acc_wrap = sum[ACC_W-1:0] - DEN_V[ACC_W-1:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (!run) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (hold) begin
      ce  <= 1'b0;
    end else if (sum >= DEN_V) begin
      acc <= acc_wrap;
      ce  <= 1'b1;
    end else begin
      acc <= sum[ACC_W-1:0];
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_seq.sv
// Clock-enable sequencer for the core.
// Synchronises the PLL lock flag, waits until lock has been stable for
// HOLD_CYCLES clk_sys cycles, then releases the core reset and starts the
// five fractional enable generators. Losing lock drops straight back to
// WAIT_LOCK, reasserting core reset and stopping every enable.
// Ports:
//   clk_sys      - 72 MHz system clock
//   reset_n      - asynchronous active-low reset
//   pll_locked   - PLL lock flag, asynchronous to clk_sys
//   pause        - synchronous; freezes the CPU/sound/YM/OKI enables
//   core_reset_n - registered active-low reset to the core (high in RUN)
//   ce_cpu, ce_snd, ce_ym, ce_oki, ce_pix - single-cycle enable pulses
//   running      - high while the FSM is in RUN
module clk_en_seq
  import clk_pkg::*;
#(
  parameter logic [15:0] HOLD_CYCLES = 16'd7200,
  parameter int          ACC_W       = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic pause,
  output logic core_reset_n,
  output logic ce_cpu,
  output logic ce_snd,
  output logic ce_ym,
  output logic ce_oki,
  output logic ce_pix,
  output logic running
);

  logic        lock_m;
  logic        lock_s;
  clk_state_e  state;
  clk_state_e  state_next;
  logic [15:0] hold_cnt;
  logic [15:0] hold_cnt_next;
  logic        run_next;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_next    = state;
    hold_cnt_next = '0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) state_next = HOLD;
      end
      HOLD: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (hold_cnt == HOLD_CYCLES - 16'd1) begin
          state_next = RUN;
        end else begin
          hold_cnt_next = hold_cnt + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s) state_next = WAIT_LOCK;
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_LOCK;
      hold_cnt     <= '0;
      core_reset_n <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_cnt_next;
      core_reset_n <= (state_next == RUN);
    end
  end

  assign running = (state == RUN);

  // Generators advance on the edge that enters RUN and are cleared on the
  // edge that leaves it, so enables line up with core_reset_n exactly and
  // lock loss beats pause.
  assign run_next = (state_next == RUN);

  frac_ce #(.NUM(CPU_NUM), .DEN(CPU_DEN), .ACC_W(ACC_W)) u_ce_cpu (
    .clk_sys (clk_sys), .reset_n (reset_n), .run (run_next), .hold (pause), .ce (ce_cpu)
  );

  frac_ce #(.NUM(SND_NUM), .DEN(SND_DEN), .ACC_W(ACC_W)) u_ce_snd (
    .clk_sys (clk_sys), .reset_n (reset_n), .run (run_next), .hold (pause), .ce (ce_snd)
  );

  frac_ce #(.NUM(YM_NUM), .DEN(YM_DEN), .ACC_W(ACC_W)) u_ce_ym (
    .clk_sys (clk_sys), .reset_n (reset_n), .run (run_next), .hold (pause), .ce (ce_ym)
  );

  frac_ce #(.NUM(OKI_NUM), .DEN(OKI_DEN), .ACC_W(ACC_W)) u_ce_oki (
    .clk_sys (clk_sys), .reset_n (reset_n), .run (run_next), .hold (pause), .ce (ce_oki)
  );

  // Pixel enable ignores pause so video timing never stalls.
  frac_ce #(.NUM(PIX_NUM), .DEN(PIX_DEN), .ACC_W(ACC_W)) u_ce_pix (
    .clk_sys (clk_sys), .reset_n (reset_n), .run (run_next), .hold (1'b0), .ce (ce_pix)
  );

endmodule

// File: tb/tb_clk_en_seq.sv
// Testbench for clk_en_seq.
// Reference model: the core is in RUN in a cycle exactly when the
// synchronised lock flag has been high for the previous HOLD+1 cycles; each
// channel counts its advancing edges n and pulses whenever floor(n*NUM/DEN)
// increases.
module tb_clk_en_seq;

  localparam int H = 7200;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset_n;
  logic pll_locked;
  logic pause;
  logic core_reset_n, ce_cpu, ce_snd, ce_ym, ce_oki, ce_pix, running;

  always #5 clk_sys = ~clk_sys;

  clk_en_seq #(.HOLD_CYCLES(16'd7200), .ACC_W(8)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .pause        (pause),
    .core_reset_n (core_reset_n),
    .ce_cpu       (ce_cpu),
    .ce_snd       (ce_snd),
    .ce_ym        (ce_ym),
    .ce_oki       (ce_oki),
    .ce_pix       (ce_pix),
    .running      (running)
  );

  // ---------------- check / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // channel order: cpu, snd, ym, oki, pix
  int num_t [5] = '{1, 7, 7, 1, 1};
  int den_t [5] = '{6, 72, 144, 18, 12};

  int   adv [5];
  logic ce_m [5];
  int   ones;
  logic d1_m, ls_m, run_m;
  logic [6:0] exp_q [$];

  int   cyc = 0;
  int   run_idx = 0;
  logic [6:0] prev_obs = '0;
  logic dbl;
  int   first_ce [5];
  int   cnt_ce [5];
  int   last_cpu_cyc = 0;

  task automatic model_edge();
    if (!reset_n) begin
      ones = 0; d1_m = 1'b0; ls_m = 1'b0; run_m = 1'b0;
      for (int ch = 0; ch < 5; ch++) begin
        adv[ch] = 0; ce_m[ch] = 1'b0;
      end
    end else begin
      if (ls_m) ones++; else ones = 0;
      ls_m  = d1_m;
      d1_m  = pll_locked;
      run_m = (ones >= H + 1);
      for (int ch = 0; ch < 5; ch++) begin
        if (!run_m) begin
          adv[ch] = 0; ce_m[ch] = 1'b0;
        end else if (pause && ch != 4) begin
          ce_m[ch] = 1'b0;
        end else begin
          adv[ch]++;
          ce_m[ch] = ((adv[ch] * num_t[ch]) / den_t[ch]) != (((adv[ch] - 1) * num_t[ch]) / den_t[ch]);
        end
      end
    end
    exp_q.push_back({run_m, run_m, ce_m[0], ce_m[1], ce_m[2], ce_m[3], ce_m[4]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    dbl = 1'b0;
    for (int ch = 0; ch < 5; ch++) begin
      first_ce[ch] = 0; cnt_ce[ch] = 0;
    end
  endtask

  task automatic tick();
    logic [6:0] obs;
    logic [6:0] e;
    @(posedge clk_sys);
    model_edge();
    #1;
    obs = {core_reset_n, running, ce_cpu, ce_snd, ce_ym, ce_oki, ce_pix};
    e = exp_q.pop_front();
    check("outs", 32'(obs), 32'(e));
    cyc++;
    if (run_m) run_idx++; else run_idx = 0;
    if (|(prev_obs[4:0] & obs[4:0])) dbl = 1'b1;
    prev_obs = obs;
    for (int ch = 0; ch < 5; ch++) begin
      if (obs[4-ch] === 1'b1) begin
        cnt_ce[ch]++;
        if (first_ce[ch] == 0 && run_m) first_ce[ch] = run_idx;
      end
    end
    if (ce_cpu === 1'b1) last_cpu_cyc = cyc;
  endtask

  task automatic wait_run(output int lat);
    lat = 0;
    while (core_reset_n !== 1'b1 && lat < H + 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_loss(output int lat);
    lat = 0;
    while (core_reset_n !== 1'b0 && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_phases(input string pfx);
    check({pfx, "_first_cpu"}, first_ce[0], 6);
    check({pfx, "_first_snd"}, first_ce[1], 11);
    check({pfx, "_first_ym"},  first_ce[2], 21);
    check({pfx, "_first_oki"}, first_ce[3], 18);
    check({pfx, "_first_pix"}, first_ce[4], 12);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int lb;
    int k;
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    pause      = 1'b0;
    clear_stats();

    // Reset with lock already high.
    repeat (10) tick();
    check("reset_state", 32'({core_reset_n, running, ce_cpu, ce_snd, ce_ym, ce_oki, ce_pix}), 0);
    reset_n = 1'b1;

    // Release: 2 sync edges + 1 edge into HOLD + H HOLD edges.
    clear_stats();
    wait_run(lat);
    check("release_latency", lat, H + 3);
    check("ce_before_run", cnt_ce[0] + cnt_ce[1] + cnt_ce[2] + cnt_ce[3] + cnt_ce[4], 0);

    // Ratios over 1440 RUN cycles (RUN cycle 1 already observed).
    repeat (1439) tick();
    check("cnt_cpu", cnt_ce[0], 240);
    check("cnt_snd", cnt_ce[1], 140);
    check("cnt_ym",  cnt_ce[2], 70);
    check("cnt_oki", cnt_ce[3], 80);
    check("cnt_pix", cnt_ce[4], 120);
    check("no_double_pulse", 32'(dbl), 0);
    check_phases("init");

    // Lock loss in RUN.
    repeat ($urandom_range(1, 30)) tick();
    pll_locked = 1'b0;
    wait_loss(lat);
    check("loss_latency", lat, 3);
    clear_stats();
    repeat (5) tick();
    check("ce_after_loss", cnt_ce[0] + cnt_ce[1] + cnt_ce[2] + cnt_ce[3] + cnt_ce[4], 0);

    // Relock gives identical first-pulse phases.
    pll_locked = 1'b1;
    clear_stats();
    wait_run(lat);
    check("relock_latency", lat, H + 3);
    repeat (29) tick();
    check_phases("relock");

    // One-cycle lock glitch while hold_cnt = 5000 restarts the full count.
    pll_locked = 1'b0;
    repeat (8) tick();
    pll_locked = 1'b1;
    repeat (3 + 5000) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    clear_stats();
    wait_run(lat);
    check("glitch_relock_latency", lat, H + 3);

    // Pause for 100 cycles in RUN.
    repeat ($urandom_range(10, 40)) tick();
    lb = last_cpu_cyc;
    clear_stats();
    pause = 1'b1;
    repeat (100) tick();
    pause = 1'b0;
    check("pause_cpu", cnt_ce[0], 0);
    check("pause_snd", cnt_ce[1], 0);
    check("pause_ym",  cnt_ce[2], 0);
    check("pause_oki", cnt_ce[3], 0);
    check("pause_pix_running", 32'(cnt_ce[4] >= 8), 1);
    k = 0;
    while (last_cpu_cyc == lb && k < 20) begin
      tick();
      k++;
    end
    check("pause_cpu_gap", last_cpu_cyc - lb, 106);

    // Random pause toggling in RUN, checked cycle by cycle.
    repeat (400) begin
      pause = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Lock loss while paused: lock loss wins.
    pause = 1'b1;
    pll_locked = 1'b0;
    wait_loss(lat);
    check("loss_with_pause_latency", lat, 3);
    repeat (4) tick();
    check("running_after_loss", 32'(running), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_en_seq.md
Name: clk_en_seq

Overview:
- Sits directly downstream of the 72 MHz system PLL and consumes its phase-0 output clock and lock flag.
- Generates all single-cycle clock enables the core needs: main 68000, sound 68000, YM2151, OKI M6295 and pixel.
- Sequences the core reset so nothing runs until PLL lock has been stable for a programmable time.
- Every downstream block runs on clk_sys and is qualified by one of these enables; no derived clocks exist.

Parameters:
- HOLD_CYCLES, 16'd7200, number of clk_sys cycles lock must stay high before core_reset_n releases (100 us at 72 MHz).
- ACC_W, 8, width of each fractional accumulator.
- CPU_NUM/CPU_DEN, 1/6, main CPU enable ratio (12 MHz).
- SND_NUM/SND_DEN, 7/72, sound CPU enable ratio (7 MHz).
- YM_NUM/YM_DEN, 7/144, YM2151 enable ratio (3.5 MHz).
- OKI_NUM/OKI_DEN, 1/18, OKI enable ratio (4 MHz).
- PIX_NUM/PIX_DEN, 1/12, pixel enable ratio (6 MHz).

Ports:
- clk_sys, in, 1, 72 MHz system clock from the PLL outclk_0.
- reset_n, in, 1, asynchronous active-low reset.
- pll_locked, in, 1, PLL lock flag; asynchronous to clk_sys.
- pause, in, 1, synchronous; freezes CPU/sound enables.
- core_reset_n, out, 1, sequenced active-low reset to the core.
- ce_cpu, out, 1, main CPU enable pulse.
- ce_snd, out, 1, sound CPU enable pulse.
- ce_ym, out, 1, YM2151 enable pulse.
- ce_oki, out, 1, OKI enable pulse.
- ce_pix, out, 1, pixel enable pulse.
- running, out, 1, high while the FSM is in RUN.

Behaviour:
- Reset: asynchronous assert, synchronous deassert. While reset_n is low:
  - All accumulators, counters and synchronisers are 0.
  - FSM is in WAIT_LOCK.
  - core_reset_n=0, all ce_*=0, running=0.
- pll_locked passes through a 2-FF synchroniser (lock_s). Latency from the pll_locked edge to lock_s is 2 cycles.
- FSM states:
  - WAIT_LOCK: hold_cnt=0. Go to HOLD when lock_s=1.
  - HOLD: hold_cnt increments each cycle. lock_s=0 returns to WAIT_LOCK and clears hold_cnt. When hold_cnt==HOLD_CYCLES-1, go to RUN.
  - RUN: core_reset_n=1 (registered, so the first RUN cycle shows it high) and running=1. lock_s=0 goes to WAIT_LOCK, and core_reset_n drops on the next edge.
- Enable generators (one per channel):
  - acc_next = acc + NUM.
  - If acc_next >= DEN: ce=1 for that cycle and acc <= acc_next - DEN.
  - Otherwise ce=0 and acc <= acc_next.
  - Enables are registered outputs: exactly 1-cycle pulses, never two consecutive cycles for any ratio ≤ 1/2.
  - Sums are computed at ACC_W+1 bits; no wrap is possible given DEN < 2^ACC_W.
- Enables run only in RUN. In every other state, accumulators are held at 0 and ce_*=0, so the first pulse phase after release is deterministic.
- pause=1 in RUN:
  - ce_cpu, ce_snd, ce_ym and ce_oki are forced to 0.
  - Their accumulators hold their values, so the phase is preserved.
  - ce_pix keeps running so video stays synced.
  - When pause drops, the channels resume from the held phase on the next cycle.
- Simultaneous events:
  - Lock loss and pause in the same cycle: lock loss wins.
  - Lock loss on the same cycle a ce would fire: that ce still fires, and the following cycle has all ce=0.
- Exact periods in RUN: ce_cpu every 6 cycles and ce_pix every 12. ce_oki every 18. ce_snd averages 7 pulses per 72 cycles with spacings of 10 or 11. ce_ym gives 7 pulses per 144 cycles.
- Initial phases after entering RUN with acc=0:
  - ce_cpu first fires in RUN cycle 6.
  - ce_pix first fires in cycle 12.
  - ce_oki first fires in cycle 18.
  - ce_snd first fires in cycle 11 (acc: 7, 14, … 77 ≥ 72).

Decomposition:
- Shared package clk_pkg holds:
  - the FSM state enum (WAIT_LOCK, HOLD, RUN);
  - the NUM/DEN constants per channel;
  - SYS_HZ=72_000_000.
- One sub-module is natural: frac_ce (parameters NUM, DEN, ACC_W; inputs clk_sys, reset_n, run, hold; output ce). It is instantiated five times.
- The top level contains the synchroniser, FSM and hold counter.

Test Plan:
- Reset/lock: reset_n low 10 cycles with pll_locked=1, then release → core_reset_n stays 0 for 2+HOLD_CYCLES cycles, then goes to 1; all ce_* are 0 before that.
- Ratios: after RUN, count over 1440 cycles → ce_cpu=240, ce_pix=120, ce_oki=80, ce_snd=140, ce_ym=70; no ce is ever high 2 consecutive cycles.
- Phase: first ce_cpu pulse in RUN cycle 6, first ce_snd pulse in cycle 11.
- Glitchy lock: pll_locked drops for 1 cycle at hold_cnt=5000 → FSM returns to WAIT_LOCK, and a full HOLD_CYCLES count restarts after relock.
- Lock loss in RUN: drop pll_locked → core_reset_n=0 within 3 cycles and all ce_* 0 from the cycle after; relock → identical first-pulse phases as the first test.
- Pause: assert pause 100 cycles in RUN → ce_cpu/ce_snd/ce_ym/ce_oki all 0 while ce_pix continues every 12 cycles; after release, ce_cpu resumes with the same residual phase (pulse gap before+after totals 6 active cycles).
